fpadd_stream_ctrl: RTL and testbench
====================================

Name: fpadd_stream_ctrl

Overview:
- Streaming front-end/back-end controller wrapped around the parameterised single-precision FloPoCo adder (34-bit operands: exn[33:32], sign[31], exp[30:23], frac[22:0]).
- Accepts operand pairs on a valid/ready stream and drives the adder's X/Y/ce.
- Tracks which adder pipeline slots hold real data and captures results into a credit-protected output FIFO, so downstream backpressure never stalls or drops adder results.
- Keeps sticky exception flags on produced results.

Parameters:
- NUM_STAGES, 2, adder latency in cycles; legal 0..6; must match the instantiated adder.
- FIFO_DEPTH, NUM_STAGES+2, output FIFO entries; must be >= NUM_STAGES+1 (elaboration error otherwise).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept a pair this cycle
- in_x  in  34  operand X (FloPoCo format)
- in_y  in  34  operand Y
- add_x  out  34  to adder X
- add_y  out  34  to adder Y
- add_ce  out  1  to adder ce
- add_r  in  34  from adder R
- out_valid  out  1  result available at FIFO head
- out_ready  in  1  downstream accepts result
- out_r  out  34  result at FIFO head
- flag_clr  in  1  synchronous clear of sticky flags
- flag_nan  out  1  sticky: some pushed result had exn=11
- flag_inf  out  1  sticky: some pushed result had exn=10

Behaviour:
- Reset (async assert, sync release): valid pipe cleared; FIFO pointers and count = 0; out_valid=0; flags=0; in_ready=1 after release. Adder internal contents are ignored because all valid bits are cleared.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- add_x/add_y = in_x/in_y combinationally.
- add_ce = in_fire | (inflight != 0).
- Valid pipe: NUM_STAGES-bit shift register vp.
  - Shifts only when add_ce=1: vp[0] <= in_fire, vp[i] <= vp[i-1].
  - inflight = popcount(vp).
  - Result strobe res_v = vp[NUM_STAGES-1] when add_ce, else 0.
  - NUM_STAGES=0: no register; res_v = in_fire, and add_r is sampled the same cycle.
- Credit rule: in_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state only (no combinational path from out_ready to in_ready). Guarantees FIFO never overflows.
- FIFO:
  - res_v pushes add_r at the clock edge.
  - First-word-fall-through: out_valid = (fifo_count != 0), out_r = mem[rd_ptr].
  - Pointers wrap at FIFO_DEPTH-1 → 0 (depth need not be a power of two).
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Pop when empty is impossible (out_valid=0).
- Latency: pair fired in cycle t appears on out_valid in cycle t+NUM_STAGES+1, provided the FIFO is empty, independent of gaps between inputs.
- Ordering: results leave strictly in input order; no loss or duplication under any in_valid/out_ready pattern.
- Flags:
  - Set on push when add_r[33:32]=11 (nan) or =10 (inf); stay set until flag_clr.
  - flag_clr and a setting push in the same cycle: flag ends set.
- add_ce low while idle: pipeline contents are frozen but are never captured, since vp is all zero.
- Reset asserted mid-operation: all in-flight and buffered results are discarded; the first result after reset comes from the first post-reset in_fire.

Test Plan:
- NUM_STAGES=2, out_ready=1, in_x=in_y=34'h1_3F80_0000 (1.0) fired in cycle 0 → out_valid=1 with out_r=34'h1_4000_0000 (2.0) in cycle 3 only; add_ce low from cycle 3 onward.
- NUM_STAGES=2, FIFO_DEPTH=4, out_ready=0, in_valid held with 8 distinct pairs → exactly 4 accepted, then in_ready=0. Raise out_ready → the 4 results drain in order; remaining pairs are accepted with no gaps; total 8 outputs in order.
- NUM_STAGES=0, back-to-back stream of 5 pairs with out_ready=1 → each result on out_valid one cycle after its in_fire; in_ready stays 1 throughout.
- Random in_valid/out_ready (50%), 1000 pairs, NUM_STAGES=4 → outputs match the reference model in order; FIFO never overflows; no output without a matching input.
- in_x=34'h3_0000_0000 (NaN) + 1.0 → flag_nan=1 after push and remains 1. flag_clr pulse → 0. flag_clr in the same cycle as a NaN push → 1.
- Assert rst_n low with 3 results in flight and 2 in FIFO → out_valid=0, flags=0, in_ready=1 after release; next pair's result is the first output.

Source files
------------

// File: rtl/fpadd_stream_ctrl_if.sv
// Operand/result stream bundle for fpadd_stream_ctrl.
//   in_valid/in_ready/in_x/in_y : operand-pair stream into the controller
//   out_valid/out_ready/out_r   : result stream out of the controller
// master = upstream/downstream side, slave = the controller.
`timescale 1ns/1ps
interface fpadd_stream_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_x;
    logic [33:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] out_r;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_r
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_r
    );
endinterface

// File: rtl/fpadd_stream_ctrl.sv
// Streaming controller around a FloPoCo single-precision adder with a fixed
// pipeline latency of NUM_STAGES cycles (34-bit FloPoCo operands).
//   clk, rst_n          : clock, asynchronous active-low reset
//   s (slave modport)   : operand stream in, result stream out (FWFT FIFO head)
//   add_x/add_y/add_ce  : drive the adder
//   add_r               : adder result, valid NUM_STAGES enabled cycles later
//   flag_clr            : clears the sticky flags
//   flag_nan/flag_inf   : sticky, set when a NaN/Inf result enters the FIFO
// A valid-bit shift register mirrors the adder pipeline so only real results
// are captured. Input acceptance is credit based: a pair is accepted only if
// its result is guaranteed a FIFO slot, so the adder never has to stall.
`timescale 1ns/1ps
module fpadd_stream_ctrl #(
    parameter int NUM_STAGES = 2,
    parameter int FIFO_DEPTH = NUM_STAGES + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fpadd_stream_ctrl_if.slave s,
    output logic [33:0]        add_x,
    output logic [33:0]        add_y,
    output logic               add_ce,
    input  logic [33:0]        add_r,
    input  logic               flag_clr,
    output logic               flag_nan,
    output logic               flag_inf
);
    // SW holds FIFO_DEPTH + NUM_STAGES, the largest possible credit sum.
    localparam int SW = $clog2(FIFO_DEPTH + NUM_STAGES + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [SW-1:0] DEPTH_W  = SW'(FIFO_DEPTH);

    generate
        if (NUM_STAGES < 0 || NUM_STAGES > 6) begin : g_bad_stages
            $error("fpadd_stream_ctrl: NUM_STAGES must be in 0..6");
        end
        if (FIFO_DEPTH < NUM_STAGES + 1) begin : g_bad_depth
            $error("fpadd_stream_ctrl: FIFO_DEPTH must be >= NUM_STAGES+1");
        end
    endgenerate

    logic          in_fire;
    logic          out_fire;
    logic          res_v;
    logic [SW-1:0] inflight;
    logic [SW-1:0] fifo_count_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic          flag_nan_reg;
    logic          flag_inf_reg;
    logic [33:0]   mem [FIFO_DEPTH];

    // Credit check uses registered state only: no out_ready -> in_ready path.
    assign s.in_ready  = (fifo_count_reg + inflight) < DEPTH_W;
    assign in_fire     = s.in_valid & s.in_ready;
    assign s.out_valid = (fifo_count_reg != '0);
    assign s.out_r     = mem[rd_ptr_reg];
    assign out_fire    = s.out_valid & s.out_ready;

    assign add_x  = s.in_x;
    assign add_y  = s.in_y;
    // Idle adder is frozen; its stale contents are never captured (vp all zero).
    assign add_ce = in_fire | (inflight != '0);

    generate
        if (NUM_STAGES == 0) begin : g_no_pipe
            // Combinational adder: result is present in the firing cycle.
            assign inflight = '0;
            assign res_v    = in_fire;
        end else begin : g_pipe
            genvar gi;
            logic [NUM_STAGES-1:0] vp_reg;
            logic [NUM_STAGES-1:0] vp_next;

            assign vp_next[0] = in_fire;
            for (gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
                assign vp_next[gi] = vp_reg[gi-1];
            end

            // Advances in lock-step with the adder's ce.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vp_reg <= '0;
                end else if (add_ce) begin
                    vp_reg <= vp_next;
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < NUM_STAGES; i++) begin
                    inflight = inflight + SW'(vp_reg[i]);
                end
            end

            assign res_v = add_ce & vp_reg[NUM_STAGES-1];
        end
    endgenerate

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    // Read is combinational so the head word falls through to out_r.
    always_ff @(posedge clk) begin
        if (res_v) begin
            mem[wr_ptr_reg] <= add_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (res_v) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (out_fire) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
            end
            case ({res_v, out_fire})
                2'b10:   fifo_count_reg <= fifo_count_reg + SW'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - SW'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // A setting push wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_nan_reg <= 1'b0;
            flag_inf_reg <= 1'b0;
        end else begin
            flag_nan_reg <= (flag_nan_reg & ~flag_clr) | (res_v & (add_r[33:32] == 2'b11));
            flag_inf_reg <= (flag_inf_reg & ~flag_clr) | (res_v & (add_r[33:32] == 2'b10));
        end
    end

    assign flag_nan = flag_nan_reg;
    assign flag_inf = flag_inf_reg;
endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
`timescale 1ns/1ps
module tb_fpadd_stream_ctrl;
    localparam logic [33:0] ONE  = 34'h1_3F80_0000;
    localparam logic [33:0] QNAN = 34'h3_0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Stand-in adder: exact for the special cases and for x+x of normal
    // numbers (exponent + 1); other pairs get a deterministic tag value.
    function automatic logic [33:0] fadd(input logic [33:0] x, input logic [33:0] y);
        if (x[33:32] == 2'b11 || y[33:32] == 2'b11) return QNAN;
        if (x[33:32] == 2'b10 && y[33:32] == 2'b10 && x[31] != y[31]) return QNAN;
        if (x[33:32] == 2'b10) return {2'b10, x[31], 31'h0};
        if (y[33:32] == 2'b10) return {2'b10, y[31], 31'h0};
        if (x == y && x[33:32] == 2'b01) return {x[33:31], x[30:23] + 8'd1, x[22:0]};
        return {2'b01, 1'b0, x[30:0] ^ {y[15:0], y[30:16]}};
    endfunction

    function automatic logic [33:0] bp_x(input int k);
        logic [7:0] e;
        e = 8'd100 + k[7:0];
        return {2'b01, 1'b0, e, 23'h0A5A5A};
    endfunction

    task automatic chk34(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUT: NUM_STAGES=2, FIFO_DEPTH=4 ----------------
    fpadd_stream_ctrl_if s2 ();
    logic [33:0] ax2, ay2, ar2;
    logic        ce2, clr2, nan2, inf2;
    logic [33:0] p2 [2];
    fpadd_stream_ctrl #(.NUM_STAGES(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .s(s2),
        .add_x(ax2), .add_y(ay2), .add_ce(ce2), .add_r(ar2),
        .flag_clr(clr2), .flag_nan(nan2), .flag_inf(inf2)
    );
    always @(posedge clk) if (ce2) begin p2[0] <= fadd(ax2, ay2); p2[1] <= p2[0]; end
    assign ar2 = p2[1];

    // ---------------- DUT: NUM_STAGES=0 (default depth 2) ----------------
    fpadd_stream_ctrl_if s0 ();
    logic [33:0] ax0, ay0, ar0;
    logic        ce0, clr0, nan0, inf0;
    fpadd_stream_ctrl #(.NUM_STAGES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .s(s0),
        .add_x(ax0), .add_y(ay0), .add_ce(ce0), .add_r(ar0),
        .flag_clr(clr0), .flag_nan(nan0), .flag_inf(inf0)
    );
    assign ar0 = fadd(ax0, ay0);

    // ---------------- DUT: NUM_STAGES=4 (default depth 6) ----------------
    fpadd_stream_ctrl_if s4 ();
    logic [33:0] ax4, ay4, ar4;
    logic        ce4, clr4, nan4, inf4;
    logic [33:0] p4 [4];
    fpadd_stream_ctrl #(.NUM_STAGES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .s(s4),
        .add_x(ax4), .add_y(ay4), .add_ce(ce4), .add_r(ar4),
        .flag_clr(clr4), .flag_nan(nan4), .flag_inf(inf4)
    );
    always @(posedge clk) if (ce4) begin
        p4[0] <= fadd(ax4, ay4);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign ar4 = p4[3];

    typedef struct {
        logic [33:0] x;
        logic [33:0] y;
        logic [33:0] r;
        logic        nan;
        logic        inf;
    } vec_t;
    vec_t vt [6];

    logic [33:0] q2 [$];
    logic [33:0] q4 [$];
    logic [33:0] exp_r;
    int k, nout, sent, got, max_occ, spurious;
    int acc_cyc [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s2.in_valid = 1'b0; s2.in_x = '0; s2.in_y = '0; s2.out_ready = 1'b1;
        s0.in_valid = 1'b0; s0.in_x = '0; s0.in_y = '0; s0.out_ready = 1'b1;
        s4.in_valid = 1'b0; s4.in_x = '0; s4.in_y = '0; s4.out_ready = 1'b1;
        clr2 = 1'b0; clr0 = 1'b0; clr4 = 1'b0;

        vt[0] = '{ONE,             ONE,            34'h1_4000_0000, 1'b0, 1'b0}; // 1+1=2
        vt[1] = '{34'h1_4000_0000, 34'h1_4000_0000, 34'h1_4080_0000, 1'b0, 1'b0}; // 2+2=4
        vt[2] = '{34'h1_BFC0_0000, 34'h1_BFC0_0000, 34'h1_C040_0000, 1'b0, 1'b0}; // -1.5-1.5=-3
        vt[3] = '{34'h1_3F00_0000, 34'h1_3F00_0000, 34'h1_3F80_0000, 1'b0, 1'b0}; // .5+.5=1
        vt[4] = '{QNAN,            ONE,            QNAN,            1'b1, 1'b0};
        vt[5] = '{34'h2_0000_0000, ONE,            34'h2_0000_0000, 1'b0, 1'b1}; // +inf+1

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_out_valid2", s2.out_valid, 1'b0);
        chk1("rst_in_ready2", s2.in_ready, 1'b1);
        chk1("rst_nan2", nan2, 1'b0);
        chk1("rst_inf2", inf2, 1'b0);
        chk1("rst_ce2", ce2, 1'b0);
        chk1("rst_in_ready0", s0.in_ready, 1'b1);
        chk1("rst_out_valid4", s4.out_valid, 1'b0);
        cyc();

        // ---- table vectors: single pair, latency NUM_STAGES+1 = 3 ----
        for (int i = 0; i < 6; i++) begin
            s2.in_x = vt[i].x; s2.in_y = vt[i].y; s2.in_valid = 1'b1;
            @(negedge clk);
            chk1($sformatf("v%0d_in_ready", i), s2.in_ready, 1'b1);
            chk1($sformatf("v%0d_ce_fire", i), ce2, 1'b1);
            cyc();
            s2.in_valid = 1'b0; s2.in_x = '0; s2.in_y = '0;
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                chk1($sformatf("v%0d_early_c%0d", i, c), s2.out_valid, 1'b0);
                cyc();
            end
            @(negedge clk);
            chk1($sformatf("v%0d_out_valid", i), s2.out_valid, 1'b1);
            chk34($sformatf("v%0d_out_r", i), s2.out_r, vt[i].r);
            chk1($sformatf("v%0d_ce_idle", i), ce2, 1'b0);
            chk1($sformatf("v%0d_nan", i), nan2, vt[i].nan);
            chk1($sformatf("v%0d_inf", i), inf2, vt[i].inf);
            $display("txn v%0d: x=%h y=%h -> r=%h", i, vt[i].x, vt[i].y, s2.out_r);
            cyc();
            @(negedge clk);
            chk1($sformatf("v%0d_single", i), s2.out_valid, 1'b0);
            clr2 = 1'b1;
            cyc();
            clr2 = 1'b0;
        end

        // ---- sticky NaN flag, clear, clear colliding with a push ----
        s2.in_x = QNAN; s2.in_y = ONE; s2.in_valid = 1'b1;
        cyc();
        s2.in_valid = 1'b0;
        repeat (2) cyc();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1($sformatf("nan_sticky_%0d", c), nan2, 1'b1);
            cyc();
        end
        clr2 = 1'b1; cyc(); clr2 = 1'b0;
        @(negedge clk);
        chk1("nan_cleared", nan2, 1'b0);
        cyc();
        s2.in_x = QNAN; s2.in_y = ONE; s2.in_valid = 1'b1;
        cyc();                       // cycle 1
        s2.in_valid = 1'b0;
        cyc();                       // cycle 2: push at end of this cycle
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        @(negedge clk);
        chk1("nan_clr_vs_push", nan2, 1'b1);
        $display("txn flag: clr with NaN push -> flag_nan=%b", nan2);
        clr2 = 1'b1; cyc(); clr2 = 1'b0;
        @(negedge clk);
        chk1("nan_cleared2", nan2, 1'b0);
        cyc();

        // ---- backpressure: credit limit 4, then drain in order ----
        s2.out_ready = 1'b0;
        k = 0; nout = 0;
        for (int cy = 0; cy < 80; cy++) begin
            if (cy == 10) s2.out_ready = 1'b1;
            s2.in_valid = (k < 8);
            s2.in_x = bp_x(k); s2.in_y = bp_x(k);
            @(negedge clk);
            if (cy == 9) begin
                chki("bp_accepted", k, 4);
                chk1("bp_in_ready_low", s2.in_ready, 1'b0);
            end
            if (s2.in_valid && s2.in_ready) begin
                q2.push_back(fadd(bp_x(k), bp_x(k)));
                acc_cyc[k] = cy;
                k++;
            end
            if (s2.out_valid && s2.out_ready) begin
                chki($sformatf("bp_sb_nonempty_%0d", nout), (q2.size() != 0) ? 1 : 0, 1);
                exp_r = (q2.size() != 0) ? q2.pop_front() : 34'h0;
                chk34($sformatf("bp_out_%0d", nout), s2.out_r, exp_r);
                $display("txn bp out %0d: r=%h", nout, s2.out_r);
                nout++;
            end
            cyc();
            if (nout == 8) break;
        end
        s2.in_valid = 1'b0;
        chki("bp_total", nout, 8);
        chki("bp_resume_cycle", acc_cyc[4], 11);
        chki("bp_no_gap", acc_cyc[7], 14);

        // ---- NUM_STAGES=0 back-to-back stream ----
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                s0.in_valid = 1'b1; s0.in_x = bp_x(20 + i); s0.in_y = ONE;
            end else begin
                s0.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 5) chk1($sformatf("st_in_ready_%0d", i), s0.in_ready, 1'b1);
            if (i > 0) begin
                chk1($sformatf("st_out_valid_%0d", i - 1), s0.out_valid, 1'b1);
                chk34($sformatf("st_out_r_%0d", i - 1), s0.out_r, fadd(bp_x(19 + i), ONE));
                $display("txn st out %0d: r=%h", i - 1, s0.out_r);
            end
            cyc();
        end
        @(negedge clk);
        chk1("st_drained", s0.out_valid, 1'b0);
        cyc();

        // ---- reset with 3 in flight and 2 buffered (NUM_STAGES=4) ----
        s4.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                s4.in_valid = 1'b1; s4.in_x = (i == 0) ? QNAN : bp_x(i); s4.in_y = ONE;
            end else begin
                s4.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 5) chk1($sformatf("rs_in_ready_%0d", i), s4.in_ready, 1'b1);
            cyc();
        end
        @(negedge clk);
        chk1("rs_pre_out_valid", s4.out_valid, 1'b1);
        chk1("rs_pre_nan", nan4, 1'b1);
        chk1("rs_pre_ce", ce4, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("rs_out_valid", s4.out_valid, 1'b0);
        chk1("rs_nan", nan4, 1'b0);
        chk1("rs_ce", ce4, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk1("rs_in_ready", s4.in_ready, 1'b1);
        chk1("rs_out_valid_rel", s4.out_valid, 1'b0);
        cyc();
        s4.out_ready = 1'b1;
        s4.in_valid = 1'b1; s4.in_x = bp_x(50); s4.in_y = ONE;
        cyc();
        s4.in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk1($sformatf("rs_no_stale_c%0d", c), s4.out_valid, 1'b0);
            cyc();
        end
        @(negedge clk);
        chk1("rs_first_valid", s4.out_valid, 1'b1);
        chk34("rs_first_r", s4.out_r, fadd(bp_x(50), ONE));
        $display("txn rs first out: r=%h", s4.out_r);
        cyc();
        @(negedge clk);
        chk1("rs_only_one", s4.out_valid, 1'b0);
        cyc();

        // ---- random valid/ready, 1000 pairs, NUM_STAGES=4 ----
        sent = 0; got = 0; max_occ = 0; spurious = 0;
        for (int cy = 0; cy < 20000 && got < 1000; cy++) begin
            s4.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            s4.in_x      = {2'b01, $urandom()};
            s4.in_y      = {2'b01, $urandom()};
            s4.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s4.out_valid && q4.size() == 0) spurious++;
            if (s4.in_valid && s4.in_ready) begin
                q4.push_back(fadd(s4.in_x, s4.in_y));
                sent++;
            end
            if (s4.out_valid && s4.out_ready) begin
                exp_r = (q4.size() != 0) ? q4.pop_front() : 34'h0;
                chk34($sformatf("rnd_out_%0d", got), s4.out_r, exp_r);
                $display("txn rnd out %0d: r=%h", got, s4.out_r);
                got++;
            end
            if (q4.size() > max_occ) max_occ = q4.size();
            cyc();
        end
        s4.in_valid = 1'b0;
        chki("rnd_outputs", got, 1000);
        chki("rnd_leftover", q4.size(), 0);
        chki("rnd_spurious", spurious, 0);
        chki("rnd_occupancy_bound", (max_occ <= 10) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
